// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed seven-segment display driver. A load strobe captures a
//   packed hex value, a per-digit decimal-point mask and a leading-zero
//   blanking flag into shadow registers. A divider then steps a digit index
//   every SCAN_DIV cycles. Each cycle the outputs are re-registered from the
//   current index and shadow contents. All display outputs are active-low.
//   Digit 0 is the rightmost digit and is taken from value[3:0].

module seg7_scan_driver #(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   AN,
    output logic                  DP,
    output logic [6:0]            A2G
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Hex nibble to active-low segments, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            4'hF:    seg = 7'h38;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Shadow registers. The whole set swaps on one edge, so a digit is never
    // built from a mix of old and new data.
    logic [4*N_DIGITS-1:0] value_q,   value_d;
    logic [N_DIGITS-1:0]   dp_mask_q, dp_mask_d;
    logic                  blank_q,   blank_d;

    // Scan timing.
    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Registered display outputs.
    logic [N_DIGITS-1:0]   an_q,  an_d;
    logic                  dp_q,  dp_d;
    logic [6:0]            a2g_q, a2g_d;

    // Per-digit selections derived from idx_q and the shadow.
    logic [3:0]            nib_s;
    logic                  dp_sel_s;
    logic [N_DIGITS-1:0]   lz_s;
    logic                  lz_sel_s;
    logic                  blank_digit_s;

    // Shadow next-state: capture the inputs only on load.
    always_comb begin
        value_d   = value_q;
        dp_mask_d = dp_mask_q;
        blank_d   = blank_q;
        if (load) begin
            value_d   = value;
            dp_mask_d = dp_mask;
            blank_d   = blank_lz;
        end else begin
            value_d   = value_q;
            dp_mask_d = dp_mask_q;
            blank_d   = blank_q;
        end
    end

    // Divider and digit index next-state. The index advances when the divider wraps.
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
            idx_d = idx_q;
        end
    end

    // lz_s[i] is set when nibbles i..N_DIGITS-1 of the shadow are all zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_s       = {N_DIGITS{1'b0}};
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (value_q[i*4 +: 4] == 4'h0);
            lz_s[i]    = zero_above;
        end
    end

    // Select the nibble, DP bit and leading-zero flag of the current digit.
    always_comb begin
        nib_s    = 4'h0;
        dp_sel_s = 1'b0;
        lz_sel_s = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            nib_s    = (idx_q == IDX_W'(i)) ? value_q[i*4 +: 4] : nib_s;
            dp_sel_s = (idx_q == IDX_W'(i)) ? dp_mask_q[i]      : dp_sel_s;
            lz_sel_s = (idx_q == IDX_W'(i)) ? lz_s[i]           : lz_sel_s;
        end
    end

    // Output next-state. Digit 0 is never blanked, so a zero value still shows "0".
    always_comb begin
        an_d          = {N_DIGITS{1'b1}};
        dp_d          = 1'b1;
        a2g_d         = 7'h7F;
        blank_digit_s = blank_q & (idx_q != {IDX_W{1'b0}}) & lz_sel_s;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_d[i] = (idx_q == IDX_W'(i)) ? 1'b0 : 1'b1;
        end
        dp_d = ~dp_sel_s;
        if (blank_digit_s) begin
            a2g_d = 7'h7F;
        end else begin
            a2g_d = hex_to_seg(nib_s);
        end
    end

    // Shadow registers: cleared on reset, loaded on the load strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q   <= {(4*N_DIGITS){1'b0}};
            dp_mask_q <= {N_DIGITS{1'b0}};
            blank_q   <= 1'b0;
        end else begin
            value_q   <= value_d;
            dp_mask_q <= dp_mask_d;
            blank_q   <= blank_d;
        end
    end

    // Scan divider and digit index. Reset aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= {DIV_W{1'b0}};
            idx_q <= {IDX_W{1'b0}};
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    // Display outputs. They are forced dark during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= {N_DIGITS{1'b1}};
            dp_q  <= 1'b1;
            a2g_q <= 7'h7F;
        end else begin
            an_q  <= an_d;
            dp_q  <= dp_d;
            a2g_q <= a2g_d;
        end
    end

    assign AN  = an_q;
    assign DP  = dp_q;
    assign A2G = a2g_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (N_DIGITS=8, SCAN_DIV=4, 2 ns clock).
// A behavioural model predicts each cycle's display outputs. The prediction is
// queued when the inputs are driven and compared once the clock edge has passed.

module tb_seg7_scan_driver;

    localparam int N = 8;
    localparam int SD = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic          clk = 1'b0;
    logic          reset;
    logic [4*N-1:0] value;
    logic [N-1:0]  dp_mask;
    logic          blank_lz;
    logic          load;
    logic [N-1:0]  AN;
    logic          DP;
    logic [6:0]    A2G;

    int tests = 0;
    int fails = 0;

    // model state
    logic [31:0] m_val;
    logic [7:0]  m_dp;
    logic        m_blank;
    int          m_div;
    int          m_idx;

    logic [15:0] exp_q[$];

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .load(load), .AN(AN), .DP(DP), .A2G(A2G)
    );

    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got AN=%h DP=%b A2G=%h, expected AN=%h DP=%b A2G=%h",
                   tag, got[15:8], got[7], got[6:0], exp[15:8], exp[7], exp[6:0]);
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [7:0]  one;
        logic [7:0]  an;
        logic [3:0]  nib;
        logic [6:0]  seg;
        logic [31:0] upper;
        one   = 8'h01;
        an    = ~(one << m_idx);
        nib   = m_val[m_idx*4 +: 4];
        upper = m_val >> (m_idx*4);
        seg   = SEG_TAB[nib];
        if (m_blank && m_idx > 0 && upper == 32'h0) seg = 7'h7F;
        return {an, ~m_dp[m_idx], seg};
    endfunction

    // One clock: predict, advance the model, let the edge pass, compare.
    task automatic tick();
        logic [15:0] e;
        if (reset) begin
            e = {8'hFF, 1'b1, 7'h7F};
            m_val = 32'h0; m_dp = 8'h0; m_blank = 1'b0; m_div = 0; m_idx = 0;
        end else begin
            e = model_out();
            if (load) begin
                m_val = value; m_dp = dp_mask; m_blank = blank_lz;
            end
            if (m_div == SD - 1) begin
                m_div = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_div = m_div + 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check("scan", {AN, DP, A2G}, exp_q.pop_front());
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] dm, input logic bl);
        value = v; dp_mask = dm; blank_lz = bl; load = 1'b1;
        tick();
        load = 1'b0;
        value = 32'hA5A5_A5A5; dp_mask = 8'hFF; blank_lz = 1'b0;  // must be ignored
    endtask

    initial begin
        logic [7:0] one8;
        logic [7:0] exp_an;
        one8 = 8'h01;
        m_val = 32'h0; m_dp = 8'h0; m_blank = 1'b0; m_div = 0; m_idx = 0;
        reset = 1'b1; value = 32'h0; dp_mask = 8'h0; blank_lz = 1'b0; load = 1'b0;

        // 1: reset held 5 cycles, then release
        for (int k = 0; k < 5; k++) tick();
        check("reset_dark", {AN, DP, A2G}, {8'hFF, 1'b1, 7'h7F});
        reset = 1'b0;
        tick();
        check("release_digit0", {AN, DP, A2G}, {8'hFE, 1'b1, 7'h01});

        // 2: plain value, full frame plus wrap
        do_load(32'h0000_1234, 8'h00, 1'b0);
        tick();
        check("load_latency", {AN, DP, A2G}, {8'hFE, 1'b1, 7'h4C});
        for (int k = 0; k < 40; k++) tick();

        // 3: leading-zero blanking, then value 0 with blanking
        do_load(32'h0000_1234, 8'h00, 1'b1);
        for (int k = 0; k < 34; k++) tick();
        do_load(32'h0000_0000, 8'h00, 1'b1);
        for (int k = 0; k < 34; k++) tick();

        // 4: full hex decode with a single DP
        do_load(32'hFEDC_BA98, 8'h04, 1'b0);
        for (int k = 0; k < 34; k++) tick();

        // 5: load on the same edge the index advances
        for (int k = 0; k < 2*SD && m_div != SD - 1; k++) tick();
        do_load(32'h5555_5555, 8'h00, 1'b0);
        exp_an = ~(one8 << m_idx);
        tick();
        check("load_on_advance", {AN, DP, A2G}, {exp_an, 1'b1, 7'h24});
        for (int k = 0; k < 8; k++) tick();

        // 6: reset mid-frame at idx 5
        do_load(32'h8765_4321, 8'hF0, 1'b0);
        for (int k = 0; k < 2*N*SD && m_idx != 5; k++) tick();
        reset = 1'b1;
        tick();
        check("midframe_reset", {AN, DP, A2G}, {8'hFF, 1'b1, 7'h7F});
        reset = 1'b0;
        tick();
        check("restart_digit0", {AN, DP, A2G}, {8'hFE, 1'b1, 7'h01});
        for (int k = 0; k < 36; k++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
